sa_8bit_ctrl: RTL and testbench
===============================

Name: sa_8bit_ctrl

Overview:
- Sequencer for the 8-bit weight-stationary systolic array (S rows x N_COL columns; x shifts right, partial sums shift down).
- Accepts one job at a time, requests and latches a weight tile, then streams a given number of input vectors with per-row skew.
- Generates the array's start/end flags and emits a per-column output-valid mask so downstream logic captures the bottom-row results.
- Sits between the job/DMA front end and the array instance.

Parameters:
- S, 64, array rows (length of the input vector)
- N_COL, 64, array columns
- PE_LAT, 1, register stages per PE hop (both right and down)
- CNT_W, 16, width of the vector counter; max job length is 2^CNT_W-1

Ports:
- I_CLK  in  1  clock
- I_RST  in  1  asynchronous active-high reset
- I_JOB_VALID  in  1  job request
- O_JOB_READY  out  1  high only in IDLE
- I_JOB_LEN  in  CNT_W  number of vectors M
- I_ABORT  in  1  cancel current job
- O_W_REQ  out  1  weight tile request
- I_W_VALID  in  1  weight tile present on DDR bus
- O_W_LATCH  out  1  one-cycle enable for the array weight register
- I_X_VALID  in  1  input vector valid
- O_X_READY  out  1  input vector accepted
- I_X  in  S*8  input vector, row i at [i*8+:8]
- O_SA_X  out  S*8  skewed vector to array I_X
- O_SA_START  out  1  array start flag
- O_SA_END  out  1  array end flag
- O_COL_VLD  out  N_COL  bit j high: bottom output of column j is valid this cycle
- O_BUSY  out  1  not IDLE
- O_DONE  out  1  one-cycle job completion pulse
- O_ABORTED  out  1  one-cycle abort acknowledge
- O_PERF_BUBBLES  out  32  bubble counter (optional feature)

Behaviour:
- Reset: all outputs 0 except O_JOB_READY=1; state IDLE; skew and tag pipelines cleared.
- States: IDLE, WLOAD, STREAM, DRAIN.
- IDLE:
  - On I_JOB_VALID, latch M and go to WLOAD.
  - M=0: stay IDLE and pulse O_DONE next cycle; no array flags.
- WLOAD:
  - O_W_REQ=1 until I_W_VALID is seen.
  - Same cycle as I_W_VALID: O_W_LATCH=1.
  - Next cycle: enter STREAM with O_SA_START=1 for one cycle.
- STREAM:
  - O_X_READY=1 while accepted count < M; a vector is accepted when I_X_VALID & O_X_READY.
  - A cycle with no valid vector injects zero data with valid tag 0 (a bubble).
  - After the M-th accept, go to DRAIN.
- Skew:
  - A vector accepted at cycle t has row i appear on O_SA_X at cycle t+1+i*PE_LAT.
  - Rows that are not yet filled carry 0.
- Tag pipeline: for a vector accepted at t, O_COL_VLD[j]=1 at cycle t+1+S*PE_LAT+j*PE_LAT.
- DRAIN:
  - Counter loads D=S*PE_LAT+(N_COL-1)*PE_LAT+1.
  - O_DONE and O_SA_END pulse on the cycle after the last O_COL_VLD[N_COL-1] for vector M-1, then return to IDLE.
- Weight stability: the weight bus must stay stable from O_W_LATCH until O_DONE; the controller never re-latches mid-job.
- I_ABORT:
  - In any non-IDLE state, the next cycle goes to IDLE.
  - O_ABORTED pulses, O_SA_END pulses, skew registers and tags are cleared (O_COL_VLD=0), and O_DONE is not asserted.
  - I_ABORT in IDLE is ignored.
- Priority: I_ABORT wins over I_W_VALID, the last accept, and DRAIN completion in the same cycle.
- I_JOB_VALID while busy is ignored (not ready).
- Counter: the accepted count saturates at M; no wrap.

Optional Feature:
- Macro: SA_8BIT_CTRL_PERF_EN
- Defined: O_PERF_BUBBLES counts STREAM cycles with O_X_READY=1 and I_X_VALID=0; it clears on job accept and saturates at 2^32-1.
- Undefined: O_PERF_BUBBLES is tied to 0 and no counter logic is generated.

Decomposition:
- Package sa_8bit_ctrl_pkg:
  - State enum encoding
  - DATA_W=8
  - Drain-length function of (S, N_COL, PE_LAT)
  - Latency function for column j
- Sub-module sa_8bit_skew: triangular delay line; row i has i*PE_LAT stages plus 1 input stage, with synchronous clear for abort.
- Controller FSM, counters and tag shift chain stay in the top module.

Test Plan:
- S=4, N_COL=4, PE_LAT=1, M=3, I_X_VALID continuous, I_W_VALID on the 2nd WLOAD cycle:
  - O_W_LATCH on that cycle, O_SA_START the next cycle.
  - Vector 0 row 3 on O_SA_X at accept+4.
  - O_COL_VLD[0] at accept+5, O_COL_VLD[3] at accept+8.
  - O_DONE at the last accept+9.
- Same configuration with I_X_VALID toggling 1,0,1,0,1: bubbles produce zero rows and no O_COL_VLD bits; with the macro defined, O_PERF_BUBBLES=2.
- M=0: O_DONE one cycle after accept, no O_W_REQ, no O_SA_START.
- I_ABORT during DRAIN with tags in flight:
  - O_COL_VLD=0 from the next cycle.
  - O_ABORTED=1 and O_SA_END=1, O_DONE=0.
  - IDLE, O_JOB_READY=1.
- I_ABORT asserted in the same cycle as I_W_VALID: no O_SA_START, return to IDLE.
- Assert I_RST asynchronously mid-STREAM: all outputs 0 immediately, O_JOB_READY=1, and the next job runs cleanly.

Source files
------------

// File: rtl/sa_8bit_ctrl_pkg.sv
// Shared types and latency helpers for the 8-bit systolic array sequencer.
// The state enum and the latency math are used by both the top and the bench.
package sa_8bit_ctrl_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WLOAD  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Cycles from the last accept until the bottom of the last column has been seen.
    function automatic int drain_len(input int s, input int n_col, input int pe_lat);
        return s * pe_lat + (n_col - 1) * pe_lat + 1;
    endfunction

    // Cycles from an accept until column j presents that vector's bottom result.
    function automatic int col_lat(input int s, input int pe_lat, input int j);
        return 1 + s * pe_lat + j * pe_lat;
    endfunction

endpackage

// File: rtl/sa_8bit_skew.sv
// Triangular input skew: row i sees the accepted vector 1 + i*PE_LAT cycles later.
// Bubbles (no load) inject zeros; clr wipes every stage in one cycle.
module sa_8bit_skew
    import sa_8bit_ctrl_pkg::*;
#(
    parameter int S      = 64,
    parameter int PE_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                load,
    input  logic [S*DATA_W-1:0] x,
    output logic [S*DATA_W-1:0] sa_x
);

    logic [S*DATA_W-1:0] in_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= '0;
        end else if (clr) begin
            in_q <= '0;
        end else begin
            in_q <= load ? x : '0;
        end
    end

    for (genvar i = 0; i < S; i++) begin : g_row
        localparam int DEPTH = i * PE_LAT;
        if (DEPTH == 0) begin : g_direct
            assign sa_x[i*DATA_W +: DATA_W] = in_q[i*DATA_W +: DATA_W];
        end else begin : g_dly
            logic [DATA_W-1:0] dly [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) dly[k] <= '0;
                end else if (clr) begin
                    for (int k = 0; k < DEPTH; k++) dly[k] <= '0;
                end else begin
                    dly[0] <= in_q[i*DATA_W +: DATA_W];
                    for (int k = 1; k < DEPTH; k++) dly[k] <= dly[k-1];
                end
            end

            assign sa_x[i*DATA_W +: DATA_W] = dly[DEPTH-1];
        end
    end

endmodule

// File: rtl/sa_8bit_ctrl.sv
// Job sequencer for the weight-stationary 8-bit systolic array: weight load, skewed
// streaming, drain and abort. Build with SA_8BIT_CTRL_PERF_EN to get the bubble counter.
module sa_8bit_ctrl
    import sa_8bit_ctrl_pkg::*;
#(
    parameter int S      = 64,
    parameter int N_COL  = 64,
    parameter int PE_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic                I_CLK,
    input  logic                I_RST,
    input  logic                I_JOB_VALID,
    output logic                O_JOB_READY,
    input  logic [CNT_W-1:0]    I_JOB_LEN,
    input  logic                I_ABORT,
    output logic                O_W_REQ,
    input  logic                I_W_VALID,
    output logic                O_W_LATCH,
    input  logic                I_X_VALID,
    output logic                O_X_READY,
    input  logic [S*DATA_W-1:0] I_X,
    output logic [S*DATA_W-1:0] O_SA_X,
    output logic                O_SA_START,
    output logic                O_SA_END,
    output logic [N_COL-1:0]    O_COL_VLD,
    output logic                O_BUSY,
    output logic                O_DONE,
    output logic                O_ABORTED,
    output logic [31:0]         O_PERF_BUBBLES
);

    localparam int DRAIN_LEN = drain_len(S, N_COL, PE_LAT);
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

    state_t               state, state_n;
    logic [CNT_W-1:0]     m_q, acc_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [DRAIN_LEN-1:0] tag_sr;
    logic job_ready, w_req, w_latch, x_ready, busy;
    logic job_take, zero_job, accept, last_accept, drain_last, abort_hit;
    logic start_q, end_q, done_q, aborted_q;

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) state <= IDLE;
        else       state <= state_n;
    end

    // Handshakes: a job transfers when I_JOB_VALID & O_JOB_READY, a vector when
    // I_X_VALID & O_X_READY; ready never depends on valid, and abort beats everything.
    always_comb begin
        state_n     = state;
        job_ready   = 1'b0;
        w_req       = 1'b0;
        w_latch     = 1'b0;
        x_ready     = 1'b0;
        busy        = 1'b1;
        job_take    = 1'b0;
        zero_job    = 1'b0;
        accept      = 1'b0;
        last_accept = 1'b0;
        drain_last  = 1'b0;
        abort_hit   = I_ABORT && (state != IDLE);
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (I_JOB_VALID) begin
                    job_take = 1'b1;
                    if (I_JOB_LEN == '0) zero_job = 1'b1;
                    else                 state_n  = WLOAD;
                end
            end
            WLOAD: begin
                w_req = 1'b1;
                if (I_ABORT) begin
                    state_n = IDLE;
                end else if (I_W_VALID) begin
                    w_latch = 1'b1;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                x_ready     = (acc_cnt < m_q);
                accept      = I_X_VALID && x_ready && !I_ABORT;
                last_accept = accept && ((acc_cnt + CNT_W'(1)) == m_q);
                if (I_ABORT)          state_n = IDLE;
                else if (last_accept) state_n = DRAIN;
            end
            DRAIN: begin
                drain_last = (drain_cnt == DRAIN_W'(1)) && !I_ABORT;
                if (I_ABORT || drain_cnt == DRAIN_W'(1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            m_q       <= '0;
            acc_cnt   <= '0;
            drain_cnt <= '0;
            start_q   <= 1'b0;
            end_q     <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            start_q   <= w_latch;
            end_q     <= drain_last || abort_hit;
            done_q    <= zero_job || drain_last;
            aborted_q <= abort_hit;
            if (job_take) begin
                m_q     <= I_JOB_LEN;
                acc_cnt <= '0;
            end else if (accept) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            if (abort_hit)                                 drain_cnt <= '0;
            else if (last_accept)                          drain_cnt <= DRAIN_W'(DRAIN_LEN);
            else if (state == DRAIN && drain_cnt != '0)    drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
    end

    // Bit k of the tag chain marks a vector accepted k+1 cycles ago.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST)          tag_sr <= '0;
        else if (abort_hit) tag_sr <= '0;
        else                tag_sr <= {tag_sr[DRAIN_LEN-2:0], accept};
    end

    for (genvar j = 0; j < N_COL; j++) begin : g_col
        assign O_COL_VLD[j] = tag_sr[col_lat(S, PE_LAT, j) - 1];
    end

    sa_8bit_skew #(
        .S      (S),
        .PE_LAT (PE_LAT)
    ) u_skew (
        .clk  (I_CLK),
        .rst  (I_RST),
        .clr  (abort_hit),
        .load (accept),
        .x    (I_X),
        .sa_x (O_SA_X)
    );

`ifdef SA_8BIT_CTRL_PERF_EN
    logic [31:0] bubbles;

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST)
            bubbles <= '0;
        else if (job_take)
            bubbles <= '0;
        else if (state == STREAM && x_ready && !I_X_VALID && bubbles != '1)
            bubbles <= bubbles + 32'd1;
    end

    assign O_PERF_BUBBLES = bubbles;
`else
    assign O_PERF_BUBBLES = 32'd0;
`endif

    assign O_JOB_READY = job_ready;
    assign O_W_REQ     = w_req;
    assign O_W_LATCH   = w_latch;
    assign O_X_READY   = x_ready;
    assign O_BUSY      = busy;
    assign O_SA_START  = start_q;
    assign O_SA_END    = end_q;
    assign O_DONE      = done_q;
    assign O_ABORTED   = aborted_q;

endmodule

// File: tb/tb_sa_8bit_ctrl.sv
// Directed bench for sa_8bit_ctrl at S=4, N_COL=4, PE_LAT=1 with hand-computed
// cycle numbers and skewed data patterns; cycle 0 of each job is the job request.
module tb_sa_8bit_ctrl;

    localparam int S      = 4;
    localparam int N_COL  = 4;
    localparam int PE_LAT = 1;
    localparam int CNT_W  = 16;
    localparam int LOG_N  = 32;

    logic               I_CLK = 1'b0;
    logic               I_RST;
    logic               I_JOB_VALID;
    logic               O_JOB_READY;
    logic [CNT_W-1:0]   I_JOB_LEN;
    logic               I_ABORT;
    logic               O_W_REQ;
    logic               I_W_VALID;
    logic               O_W_LATCH;
    logic               I_X_VALID;
    logic               O_X_READY;
    logic [S*8-1:0]     I_X;
    logic [S*8-1:0]     O_SA_X;
    logic               O_SA_START;
    logic               O_SA_END;
    logic [N_COL-1:0]   O_COL_VLD;
    logic               O_BUSY;
    logic               O_DONE;
    logic               O_ABORTED;
    logic [31:0]        O_PERF_BUBBLES;

    sa_8bit_ctrl #(
        .S(S), .N_COL(N_COL), .PE_LAT(PE_LAT), .CNT_W(CNT_W)
    ) dut (
        .I_CLK(I_CLK), .I_RST(I_RST),
        .I_JOB_VALID(I_JOB_VALID), .O_JOB_READY(O_JOB_READY), .I_JOB_LEN(I_JOB_LEN),
        .I_ABORT(I_ABORT), .O_W_REQ(O_W_REQ), .I_W_VALID(I_W_VALID), .O_W_LATCH(O_W_LATCH),
        .I_X_VALID(I_X_VALID), .O_X_READY(O_X_READY), .I_X(I_X), .O_SA_X(O_SA_X),
        .O_SA_START(O_SA_START), .O_SA_END(O_SA_END), .O_COL_VLD(O_COL_VLD),
        .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_ABORTED(O_ABORTED),
        .O_PERF_BUBBLES(O_PERF_BUBBLES)
    );

    // clock / reset
    always #5 I_CLK = ~I_CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0]      exp_q[$];
    logic [31:0]      vld_q[$];
    logic [S*8-1:0]   sax_log   [LOG_N];
    logic [N_COL-1:0] vld_log   [LOG_N];
    logic             ready_log [LOG_N];
    logic             wreq_log  [LOG_N];
    logic             wlat_log  [LOG_N];
    logic             xrdy_log  [LOG_N];
    logic             start_log [LOG_N];
    logic             end_log   [LOG_N];
    logic             done_log  [LOG_N];
    logic             abrt_log  [LOG_N];
    logic             busy_log  [LOG_N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [S*8-1:0] vec(input int k);
        logic [S*8-1:0] v;
        for (int i = 0; i < S; i++) v[i*8 +: 8] = 8'(16 * (k + 1) + i);
        return v;
    endfunction

    task automatic clear_inputs();
        I_JOB_VALID = 1'b0;
        I_JOB_LEN   = '0;
        I_ABORT     = 1'b0;
        I_W_VALID   = 1'b0;
        I_X_VALID   = 1'b0;
        I_X         = '0;
    endtask

    // driver: one job, cycle 0 = request; xpat bit n drives I_X_VALID on stream cycle n
    task automatic run_job(input int len, input int w_cyc, input logic [15:0] xpat,
                           input int abort_cyc, input int ncyc);
        int k;
        int idx;
        k = 0;
        for (int c = 0; c < ncyc; c++) begin
            cyc         = c;
            idx         = c - (w_cyc + 1);
            I_JOB_VALID = (c == 0);
            I_JOB_LEN   = CNT_W'(len);
            I_W_VALID   = (c == w_cyc);
            I_ABORT     = (c == abort_cyc);
            I_X_VALID   = (w_cyc >= 0 && idx >= 0 && idx < 16) ? xpat[idx] : 1'b0;
            I_X         = I_X_VALID ? vec(k) : 32'hDEAD_BEEF;
            #1;
            sax_log[c]   = O_SA_X;
            vld_log[c]   = O_COL_VLD;
            ready_log[c] = O_JOB_READY;
            wreq_log[c]  = O_W_REQ;
            wlat_log[c]  = O_W_LATCH;
            xrdy_log[c]  = O_X_READY;
            start_log[c] = O_SA_START;
            end_log[c]   = O_SA_END;
            done_log[c]  = O_DONE;
            abrt_log[c]  = O_ABORTED;
            busy_log[c]  = O_BUSY;
            if (I_X_VALID && O_X_READY) k++;
            @(posedge I_CLK);
            #1;
        end
        clear_inputs();
    endtask

    task automatic check_basic_job(input string pfx);
        check({pfx, "_ready0"}, 32'(ready_log[0]), 32'd1);
        check({pfx, "_wreq1"},  32'(wreq_log[1]),  32'd1);
        check({pfx, "_wlat1"},  32'(wlat_log[1]),  32'd0);
        check({pfx, "_wlat2"},  32'(wlat_log[2]),  32'd1);
        check({pfx, "_start3"}, 32'(start_log[3]), 32'd1);
        check({pfx, "_start4"}, 32'(start_log[4]), 32'd0);
        check({pfx, "_done13"}, 32'(done_log[13]), 32'd0);
        check({pfx, "_done14"}, 32'(done_log[14]), 32'd1);
        check({pfx, "_end14"},  32'(end_log[14]),  32'd1);
        check({pfx, "_done15"}, 32'(done_log[15]), 32'd0);
        check({pfx, "_ready15"},32'(ready_log[15]),32'd1);
        check({pfx, "_sax7"},   32'(sax_log[7]),   32'h1322_3100);
        check({pfx, "_vld10"},  32'(vld_log[10]),  32'h7);
    endtask

    // scoreboard for the continuous M=3 job: accepts at cycles 3,4,5
    initial begin
        int any_start;
        int any_vld;
        clear_inputs();
        I_RST = 1'b1;
        #1;
        check("rst_job_ready", 32'(O_JOB_READY), 32'd1);
        check("rst_busy",      32'(O_BUSY),      32'd0);
        check("rst_done",      32'(O_DONE),      32'd0);
        check("rst_sa_x",      32'(O_SA_X),      32'd0);
        check("rst_col_vld",   32'(O_COL_VLD),   32'd0);
        check("rst_perf",      O_PERF_BUBBLES,   32'd0);
        @(posedge I_CLK);
        #2;
        I_RST = 1'b0;
        @(posedge I_CLK);
        #1;

        // continuous stream, weights on the 2nd WLOAD cycle
        exp_q = '{32'h0000_0000, 32'h0000_0010, 32'h0000_1120, 32'h0012_2130,
                  32'h1322_3100, 32'h2332_0000, 32'h3300_0000, 32'h0000_0000};
        vld_q = '{32'h0, 32'h1, 32'h3, 32'h7, 32'he, 32'hc, 32'h8, 32'h0};
        run_job(3, 2, 16'hFFFF, -1, 18);
        check_basic_job("cont");
        for (int c = 3; c <= 10; c++) begin
            cyc = c;
            check("cont_sa_x", 32'(sax_log[c]), exp_q.pop_front());
        end
        for (int c = 7; c <= 14; c++) begin
            cyc = c;
            check("cont_col_vld", 32'(vld_log[c]), vld_q.pop_front());
        end

        // toggling valid 1,0,1,0,1: accepts at 3,5,7
        run_job(3, 2, 16'h0015, -1, 20);
        check("tog_sa_x5",  32'(sax_log[5]),  32'h0000_1100);
        check("tog_sa_x6",  32'(sax_log[6]),  32'h0012_0020);
        check("tog_vld9",   32'(vld_log[9]),  32'h2);
        check("tog_vld11",  32'(vld_log[11]), 32'ha);
        check("tog_done15", 32'(done_log[15]), 32'd0);
        check("tog_done16", 32'(done_log[16]), 32'd1);
`ifdef SA_8BIT_CTRL_PERF_EN
        check("tog_perf", O_PERF_BUBBLES, 32'd2);
`else
        check("tog_perf", O_PERF_BUBBLES, 32'd0);
`endif

        // zero-length job
        run_job(0, -1, 16'h0000, -1, 4);
        any_start = 0;
        for (int c = 0; c < 4; c++) any_start += int'(start_log[c]) + int'(wreq_log[c]);
        check("m0_done0",    32'(done_log[0]),  32'd0);
        check("m0_done1",    32'(done_log[1]),  32'd1);
        check("m0_done2",    32'(done_log[2]),  32'd0);
        check("m0_busy1",    32'(busy_log[1]),  32'd0);
        check("m0_no_flags", 32'(any_start),    32'd0);

        // abort during DRAIN with tags in flight
        run_job(3, 2, 16'hFFFF, 9, 16);
        any_vld = 0;
        for (int c = 10; c < 16; c++) any_vld += int'(vld_log[c] != '0) + int'(done_log[c]);
        check("abd_vld9",    32'(vld_log[9]),   32'h3);
        check("abd_vld10",   32'(vld_log[10]),  32'h0);
        check("abd_aborted", 32'(abrt_log[10]), 32'd1);
        check("abd_end",     32'(end_log[10]),  32'd1);
        check("abd_done",    32'(done_log[10]), 32'd0);
        check("abd_ready",   32'(ready_log[10]),32'd1);
        check("abd_quiet",   32'(any_vld),      32'd0);

        // abort in the same cycle as the weight valid
        run_job(3, 1, 16'hFFFF, 1, 6);
        check("abw_start",   32'(start_log[2]), 32'd0);
        check("abw_aborted", 32'(abrt_log[2]),  32'd1);
        check("abw_ready",   32'(ready_log[2]), 32'd1);
        check("abw_xready",  32'(xrdy_log[2]),  32'd0);
        check("abw_wreq",    32'(wreq_log[2]),  32'd0);

        // asynchronous reset mid-STREAM, then a clean job
        run_job(3, 2, 16'hFFFF, -1, 5);
        check("ar_pre_busy", 32'(O_BUSY), 32'd1);
        #2;
        I_RST = 1'b1;
        #1;
        check("ar_job_ready", 32'(O_JOB_READY), 32'd1);
        check("ar_busy",      32'(O_BUSY),      32'd0);
        check("ar_x_ready",   32'(O_X_READY),   32'd0);
        check("ar_sa_x",      32'(O_SA_X),      32'd0);
        check("ar_col_vld",   32'(O_COL_VLD),   32'd0);
        check("ar_start",     32'(O_SA_START),  32'd0);
        @(posedge I_CLK);
        #2;
        I_RST = 1'b0;
        @(posedge I_CLK);
        #1;
        run_job(3, 2, 16'hFFFF, -1, 18);
        check_basic_job("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout: got no finish, expected finish before 20000");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
